// File: rtl/row_stream_bridge_pkg.sv
// row_stream_bridge_pkg: shared state enum, row geometry constants and word-slice helper
package row_stream_bridge_pkg;
    localparam int WORD_WIDTH     = 16;
    localparam int ROW_WORDS      = 16;
    localparam int ROW_BITS       = ROW_WORDS * WORD_WIDTH;
    localparam int ROW_ADDR_WIDTH = 10;
    localparam int IDX_WIDTH      = $clog2(ROW_WORDS);
    localparam int BIT_WIDTH      = $clog2(ROW_BITS);
    typedef enum logic [2:0] {IDLE, FILL, WRITE, READ_REQ, READ_WAIT, DRAIN} state_t;
    function automatic logic [BIT_WIDTH-1:0] word_lsb(input logic [IDX_WIDTH-1:0] k);
        return BIT_WIDTH'((ROW_WORDS - 1 - int'(k)) * WORD_WIDTH);
    endfunction
endpackage

// File: rtl/row_stream_bridge_if.sv
// row_stream_bridge_if: command, word stream and memory row signals; ROW_STREAM_LAST_EN adds s_last/m_last/error
interface row_stream_bridge_if;
    import row_stream_bridge_pkg::*;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ROW_ADDR_WIDTH-1:0] cmd_row;
    logic [ROW_ADDR_WIDTH:0]   cmd_count;
    logic                      s_valid;
    logic                      s_ready;
    logic [WORD_WIDTH-1:0]     s_data;
    logic                      m_valid;
    logic                      m_ready;
    logic [WORD_WIDTH-1:0]     m_data;
    logic [ROW_ADDR_WIDTH-1:0] mem_row_addr;
    logic                      mem_row_write;
    logic [ROW_BITS-1:0]       mem_row_data;
    logic [ROW_BITS-1:0]       mem_row_data_in;
    logic                      busy;
    logic                      done;
`ifdef ROW_STREAM_LAST_EN
    logic                      s_last;
    logic                      m_last;
    logic                      error;
`endif
    modport slave (
        input  cmd_valid, cmd_write, cmd_row, cmd_count, s_valid, s_data, m_ready, mem_row_data_in,
        output cmd_ready, s_ready, m_valid, m_data, mem_row_addr, mem_row_write, mem_row_data, busy, done
`ifdef ROW_STREAM_LAST_EN
        , input s_last, output m_last, error
`endif
    );
    modport master (
        output cmd_valid, cmd_write, cmd_row, cmd_count, s_valid, s_data, m_ready, mem_row_data_in,
        input  cmd_ready, s_ready, m_valid, m_data, mem_row_addr, mem_row_write, mem_row_data, busy, done
`ifdef ROW_STREAM_LAST_EN
        , output s_last, input m_last, error
`endif
    );
endinterface

// File: rtl/row_stream_bridge_row_shift_buffer.sv
// row_shift_buffer: 256-bit row register with indexed word load/select and full-row parallel load
module row_shift_buffer
    import row_stream_bridge_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  word_load,
    input  logic                  row_load,
    input  logic [IDX_WIDTH-1:0]  word_idx,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic [ROW_BITS-1:0]   row_in,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [WORD_WIDTH-1:0] word_out
);
    logic [ROW_BITS-1:0] row_q;
    // full-row capture from memory wins; otherwise one stream word lands at its slice
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) row_q <= '0;
        else if (row_load) row_q <= row_in;
        else if (word_load) row_q[word_lsb(word_idx) +: WORD_WIDTH] <= word_in;
    assign row_out  = row_q;
    assign word_out = row_q[word_lsb(word_idx) +: WORD_WIDTH];
endmodule

// File: rtl/row_stream_bridge.sv
// row_stream_bridge: moves 16-word rows between a memory row port and valid/ready word streams (ROW_STREAM_LAST_EN: framing signals)
module row_stream_bridge
    import row_stream_bridge_pkg::*;
(
    input logic               clock,
    input logic               reset_n,
    row_stream_bridge_if.slave bus
);
    state_t                    state, state_d;
    logic [IDX_WIDTH-1:0]      idx, idx_d;
    logic [ROW_ADDR_WIDTH-1:0] row, row_d;
    logic [ROW_ADDR_WIDTH:0]   rem, rem_d;
    logic                      done_q, done_d;
    logic                      cmd_fire, s_fire, m_fire, row_end, last_row;
    assign cmd_fire = state == IDLE && bus.cmd_valid;
    assign s_fire   = state == FILL && bus.s_valid;
    assign m_fire   = state == DRAIN && bus.m_ready;
    assign row_end  = idx == IDX_WIDTH'(ROW_WORDS - 1);
    assign last_row = rem == {{ROW_ADDR_WIDTH{1'b0}}, 1'b1};
    row_shift_buffer u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .word_load (s_fire),
        .row_load  (state == READ_WAIT),
        .word_idx  (idx),
        .word_in   (bus.s_data),
        .row_in    (bus.mem_row_data_in),
        .row_out   (bus.mem_row_data),
        .word_out  (bus.m_data)
    );
    // state, word index, row pointer, remaining rows and done pulse registers
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            row    <= '0;
            rem    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            row    <= row_d;
            rem    <= rem_d;
            done_q <= done_d;
        end
    // next-state: a zero-count command completes straight from IDLE; rows advance with natural address wrap
    always_comb begin
        state_d = state;
        idx_d   = idx;
        row_d   = row;
        rem_d   = rem;
        done_d  = 1'b0;
        case (state)
            IDLE: if (cmd_fire) begin
                row_d   = bus.cmd_row;
                rem_d   = bus.cmd_count;
                idx_d   = '0;
                done_d  = bus.cmd_count == '0;
                state_d = bus.cmd_count == '0 ? IDLE : bus.cmd_write ? FILL : READ_REQ;
            end
            FILL: if (s_fire) begin
                idx_d   = idx + 1'b1;
                state_d = row_end ? WRITE : FILL;
            end
            WRITE: begin
                row_d   = row + 1'b1;
                rem_d   = rem - 1'b1;
                idx_d   = '0;
                done_d  = last_row;
                state_d = last_row ? IDLE : FILL;
            end
            READ_REQ: state_d = READ_WAIT;
            READ_WAIT: begin
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (m_fire) begin
                idx_d = idx + 1'b1;
                if (row_end) begin
                    row_d   = row + 1'b1;
                    rem_d   = rem - 1'b1;
                    done_d  = last_row;
                    state_d = last_row ? IDLE : READ_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.cmd_ready     = state == IDLE;
    assign bus.busy          = state != IDLE;
    assign bus.s_ready       = state == FILL;
    assign bus.m_valid       = state == DRAIN;
    assign bus.mem_row_write = state == WRITE;
    assign bus.mem_row_addr  = row;
    assign bus.done          = done_q;
`ifdef ROW_STREAM_LAST_EN
    logic error_q;
    // sticky framing error when s_last disagrees with the command's final word; a new command clears it
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) error_q <= 1'b0;
        else if (cmd_fire) error_q <= 1'b0;
        else if (s_fire && bus.s_last != (row_end && last_row)) error_q <= 1'b1;
    assign bus.error  = error_q;
    assign bus.m_last = state == DRAIN && row_end && last_row;
`endif
endmodule

// File: tb/tb_row_stream_bridge.sv
// tb_row_stream_bridge: randomized scenarios against a queue-based row/word reference model
module tb_row_stream_bridge;
    import row_stream_bridge_pkg::*;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [ROW_BITS-1:0] mem [0:1023];
    row_stream_bridge_if bus();
    row_stream_bridge dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    // memory model: row data appears one cycle after the address
    always @(posedge clock) bus.mem_row_data_in <= mem[bus.mem_row_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.m_valid, bus.s_ready, bus.mem_row_write} !== 6'b100000 ||
            bus.mem_row_addr !== '0 || bus.m_data !== '0 || bus.mem_row_data !== '0)
            begin errors++; $display("FAIL reset_values: flags %b addr %h m_data %h", {bus.cmd_ready, bus.busy, bus.done, bus.m_valid, bus.s_ready, bus.mem_row_write}, bus.mem_row_addr, bus.m_data); end
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL reset_release: cmd_ready %b busy %b want 1 0", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_write(input string name, input logic [9:0] row, input int count, input bit seq, input int stall_pct);
        logic [15:0] words[$];
        logic [ROW_BITS-1:0] exp_data[$];
        logic [9:0] exp_addr[$];
        logic [ROW_BITS-1:0] r;
        logic [15:0] w;
        int cyc = 0;
        int strobe_cyc = -10;
        bit fin = 0;
        for (int i = 0; i < count; i++) begin
            r = '0;
            for (int k = 0; k < ROW_WORDS; k++) begin
                w = seq ? 16'(i * 16 + k) : 16'($urandom);
                words.push_back(w);
                r = {r[ROW_BITS-17:0], w};
            end
            exp_data.push_back(r);
            exp_addr.push_back(10'(int'(row) + i));
        end
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_row = row; bus.cmd_count = 11'(count);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready: got %b want 1", name, bus.cmd_ready); end
        step();
        bus.cmd_valid = 1'b0;
        while (!fin && cyc < 40 * count + 40) begin
            bus.s_valid = words.size() > 0 && $urandom_range(99) >= stall_pct;
            bus.s_data = bus.s_valid ? words[0] : 16'($urandom);
`ifdef ROW_STREAM_LAST_EN
            bus.s_last = words.size() == 1;
`endif
            if (bus.s_valid && bus.s_ready) void'(words.pop_front());
            if (bus.mem_row_write) begin
                checks++;
                if (exp_addr.size() == 0) begin errors++; $display("FAIL %s extra_strobe: addr %h", name, bus.mem_row_addr); end
                else begin
                    if (bus.mem_row_addr !== exp_addr[0] || bus.mem_row_data !== exp_data[0])
                        begin errors++; $display("FAIL %s row_write: got %h/%h want %h/%h", name, bus.mem_row_addr, bus.mem_row_data, exp_addr[0], exp_data[0]); end
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                strobe_cyc = cyc;
            end
            if (bus.done) begin
                checks++;
                if (exp_addr.size() != 0 || cyc != strobe_cyc + 1)
                    begin errors++; $display("FAIL %s done_timing: at cycle %0d, last strobe %0d, rows left %0d", name, cyc, strobe_cyc, exp_addr.size()); end
                if (stall_pct == 0) begin
                    checks++;
                    if (cyc != 17 * count) begin errors++; $display("FAIL %s throughput: done at %0d want %0d", name, cyc, 17 * count); end
                end
                fin = 1;
            end
            step();
            cyc++;
        end
        bus.s_valid = 1'b0;
`ifdef ROW_STREAM_LAST_EN
        bus.s_last = 1'b0;
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL %s error_flag: got %b want 0", name, bus.error); end
`endif
        checks++;
        if (!fin) begin errors++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc); end
        else if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s done_pulse: done %b busy %b want 0 0", name, bus.done, bus.busy); end
    endtask

    task automatic test_read(input string name, input logic [9:0] row, input int count, input int mode);
        logic [15:0] exp_w[$];
        logic [ROW_BITS-1:0] r;
        logic [15:0] prev = '0;
        bit stalled = 0;
        bit fin = 0;
        int cyc = 0;
        int last_hs = -10;
        int nstrobe = 0;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < 8; j++) r = {r[ROW_BITS-33:0], 32'($urandom)};
            mem[10'(int'(row) + i)] = r;
            for (int k = 0; k < ROW_WORDS; k++) begin
                exp_w.push_back(r[ROW_BITS-1 -: 16]);
                r = r << 16;
            end
        end
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_row = row; bus.cmd_count = 11'(count);
        step();
        bus.cmd_valid = 1'b0;
        while (!fin && cyc < 60 * count + 40) begin
            bus.m_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(1));
            if (bus.mem_row_write || bus.s_ready) nstrobe++;
            if (bus.m_valid) begin
                checks++;
                if (exp_w.size() == 0) begin errors++; $display("FAIL %s extra_word: got %h", name, bus.m_data); end
                else if (bus.m_data !== exp_w[0]) begin errors++; $display("FAIL %s word: got %h want %h (%0d left)", name, bus.m_data, exp_w[0], exp_w.size()); end
                if (stalled) begin
                    checks++;
                    if (bus.m_data !== prev) begin errors++; $display("FAIL %s stall_hold: got %h want %h", name, bus.m_data, prev); end
                end
`ifdef ROW_STREAM_LAST_EN
                checks++;
                if (bus.m_last !== (exp_w.size() == 1)) begin errors++; $display("FAIL %s m_last: got %b want %b", name, bus.m_last, exp_w.size() == 1); end
`endif
                stalled = !bus.m_ready;
                prev = bus.m_data;
                if (bus.m_ready && exp_w.size() > 0) begin
                    void'(exp_w.pop_front());
                    last_hs = cyc;
                end
            end else stalled = 0;
            if (bus.done) begin
                checks++;
                if (exp_w.size() != 0 || cyc != last_hs + 1)
                    begin errors++; $display("FAIL %s done_timing: at cycle %0d, last handshake %0d, words left %0d", name, cyc, last_hs, exp_w.size()); end
                if (mode == 0) begin
                    checks++;
                    if (cyc != 18 * count) begin errors++; $display("FAIL %s throughput: done at %0d want %0d", name, cyc, 18 * count); end
                end
                fin = 1;
            end
            step();
            cyc++;
        end
        bus.m_ready = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc); end
        checks++;
        if (nstrobe != 0) begin errors++; $display("FAIL %s write_side_active: %0d cycles want 0", name, nstrobe); end
    endtask

    task automatic test_zero_count();
        for (int d = 0; d < 2; d++) begin
            int bad = 0;
            bus.cmd_valid = 1'b1; bus.cmd_write = d[0]; bus.cmd_row = 10'($urandom); bus.cmd_count = '0;
            step();
            bus.cmd_valid = 1'b0; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
                begin errors++; $display("FAIL zero_count_done dir %0d: done %b busy %b cmd_ready %b want 1 0 1", d, bus.done, bus.busy, bus.cmd_ready); end
            repeat (6) begin
                step();
                if (bus.mem_row_write || bus.m_valid || bus.s_ready || bus.done) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL zero_count_quiet dir %0d: %0d active cycles want 0", d, bad); end
            bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_row = 10'd100; bus.cmd_count = 11'd3;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 16'($urandom);
            step();
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL mid_fill_busy: busy %b s_ready %b want 1 1", bus.busy, bus.s_ready); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.m_valid, bus.s_ready, bus.mem_row_write} !== 6'b100000 ||
            bus.mem_row_addr !== '0 || bus.m_data !== '0 || bus.mem_row_data !== '0)
            begin errors++; $display("FAIL mid_fill_reset: flags %b addr %h m_data %h", {bus.cmd_ready, bus.busy, bus.done, bus.m_valid, bus.s_ready, bus.mem_row_write}, bus.mem_row_addr, bus.m_data); end
        step();
        step();
        #1 reset_n = 1'b1;
        repeat (20) begin
            step();
            if (bus.mem_row_write || bus.s_ready || bus.busy) bad++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_fill_no_strobe: %0d active cycles want 0", bad); end
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.mem_row_addr !== '0 || bus.mem_row_data !== '0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL mid_fill_after: cmd_ready %b addr %h done %b", bus.cmd_ready, bus.mem_row_addr, bus.done); end
    endtask

`ifdef ROW_STREAM_LAST_EN
    task automatic test_last();
        int cyc = 0;
        int sent = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_row = 10'd42; bus.cmd_count = 11'd1;
        step();
        bus.cmd_valid = 1'b0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            bus.s_valid = sent < 16; bus.s_data = 16'($urandom); bus.s_last = sent == 3;
            if (bus.s_valid && bus.s_ready) sent++;
            step();
            cyc++;
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        checks++;
        if (bus.error !== 1'b1 || cyc >= 100) begin errors++; $display("FAIL last_error_set: error %b cycles %0d want 1", bus.error, cyc); end
        bus.cmd_valid = 1'b1; bus.cmd_count = '0;
        step();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL last_error_clear: got %b want 0", bus.error); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_row = '0; bus.cmd_count = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
`ifdef ROW_STREAM_LAST_EN
        bus.s_last = 1'b0;
`endif
        test_reset();
        test_write("write_1row", 10'd5, 1, 1'b1, 0);
        test_read("read_2rows_bp", 10'd7, 2, 1);
        test_write("write_wrap", 10'd1023, 2, 1'b0, 0);
        test_zero_count();
        test_reset_mid_fill();
        test_write("write_rand_stall", 10'($urandom), 3, 1'b0, 30);
        test_read("read_wrap_rand", 10'd1022, 3, 2);
        test_read("read_full_rate", 10'($urandom), 2, 0);
        test_write("write_back_to_back", 10'($urandom), 4, 1'b0, 0);
`ifdef ROW_STREAM_LAST_EN
        test_read("read_last_1row", 10'd300, 1, 0);
        test_last();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
